ddr3_app_emu: RTL and testbench

Synthesizable responder for the Gowin DDR3 IP native application interface, backed by on-chip block RAM instead of external DDR3. It accepts the cmd/addr, write-data and read-data traffic that the DDR3 port arbiter issues, so the full memory path can run in simulation, and on boards without DDR3 fitted, with no other change to the design. It also injects calibration delay, periodic refresh stalls and protocol-error detection, so arbiter corner cases are exercised.

---
 rtl/ddr3_app_pkg.sv | 12 +
 rtl/ddr3_app_mem.sv | 37 +++
 rtl/ddr3_app_emu.sv | 186 ++++++++++++++++++
 tb/tb_ddr3_app_emu.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_app_pkg.sv
// rtl/ddr3_app_pkg.sv - shared command codes and state type for the DDR3 app-interface emulator
package ddr3_app_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic {
        CALIB = 1'b0,
        RUN   = 1'b1
    } app_state_t;

endpackage

// File: rtl/ddr3_app_mem.sv
// rtl/ddr3_app_mem.sv - simple dual-port byte-enable block RAM with registered read port
module ddr3_app_mem #(
    parameter int LINES = 1024,
    parameter int DW    = 128,
    parameter int AW    = $clog2(LINES)
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [DW/8-1:0] wr_be,
    input  logic [DW-1:0]   wr_data,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr,
    output logic [DW-1:0]   rd_data
);

    logic [DW-1:0] mem [LINES];

    // Byte-enabled write port; contents are never reset so they survive a controller reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < DW/8; b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // Registered read port (read-first with respect to a same-edge write)
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ddr3_app_emu.sv
// rtl/ddr3_app_emu.sv - BRAM-backed responder for the DDR3 native application interface
module ddr3_app_emu
    import ddr3_app_pkg::*;
#(
    parameter int DDR_ADDR_WIDTH = 29,
    parameter int DDR_DATA_WIDTH = 128,
    parameter int MEM_LINES      = 1024,
    parameter int CALIB_CYCLES   = 64,
    parameter int READ_LATENCY   = 8,
    parameter int REFRESH_PERIOD = 256,
    parameter int REFRESH_BUSY   = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    output logic                        init_calib_complete,
    output logic                        cmd_ready,
    input  logic [2:0]                  cmd,
    input  logic                        cmd_en,
    input  logic [DDR_ADDR_WIDTH-1:0]   addr,
    output logic                        wr_data_rdy,
    input  logic [DDR_DATA_WIDTH-1:0]   wr_data,
    input  logic                        wr_data_en,
    input  logic                        wr_data_end,
    input  logic [DDR_DATA_WIDTH/8-1:0] wr_data_mask,
    output logic [DDR_DATA_WIDTH-1:0]   rd_data,
    output logic                        rd_data_valid,
    output logic                        rd_data_end,
    output logic                        proto_err
);

    localparam int LW = $clog2(MEM_LINES);
    localparam int MW = DDR_DATA_WIDTH / 8;
    localparam int CW = $clog2(CALIB_CYCLES + 1);
    localparam int RL = READ_LATENCY;

    app_state_t state_q, state_d;
    logic [CW-1:0] calib_cnt;
    logic refresh_busy;

    logic                      wbuf_full;
    logic [DDR_DATA_WIDTH-1:0] wbuf_data;
    logic [MW-1:0]             wbuf_mask;
    logic                      wpend;
    logic [LW-1:0]             widx;

    logic [RL-1:0]             rv;
    logic [LW-1:0]             ridx [RL-1];
    logic [DDR_DATA_WIDTH-1:0] ram_q;

    logic [LW-1:0] line;
    logic cmd_acc, wr_acc, rd_acc, beat_acc, commit, bad_cmd;
    logic addr_unused;

    // Higher address bits alias onto the backing line index; the burst-offset bits are don't-care
    assign line        = addr[3 +: LW];
    assign addr_unused = ^{addr[2:0], addr[DDR_ADDR_WIDTH-1:3+LW]};

    assign cmd_acc  = cmd_en && cmd_ready;
    assign wr_acc   = cmd_acc && (cmd == CMD_WRITE);
    assign rd_acc   = cmd_acc && (cmd == CMD_READ);
    assign bad_cmd  = cmd_acc && (cmd != CMD_WRITE) && (cmd != CMD_READ);
    assign beat_acc = wr_data_en && wr_data_rdy;
    assign commit   = wpend && wbuf_full;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= CALIB;
        else          state_q <= state_d;
    end

    // Next state and handshake outputs; a pending write blocks new commands until it commits
    always_comb begin
        state_d             = state_q;
        init_calib_complete = 1'b0;
        cmd_ready           = 1'b0;
        wr_data_rdy         = 1'b0;
        case (state_q)
            CALIB: begin
                if (calib_cnt == CW'(CALIB_CYCLES - 1)) state_d = RUN;
            end
            RUN: begin
                init_calib_complete = 1'b1;
                cmd_ready           = !wpend && !refresh_busy;
                wr_data_rdy         = !wbuf_full;
            end
            default: state_d = CALIB;
        endcase
    end

    // Calibration delay counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                  calib_cnt <= '0;
        else if (state_q == CALIB && state_d == CALIB) calib_cnt <= calib_cnt + 1'b1;
    end

    generate
        if (REFRESH_PERIOD > 0) begin : g_refresh
            localparam int RW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
            logic [RW-1:0] ref_cnt;

            // Free-running refresh phase counter; the stall occupies the tail of each period
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    ref_cnt <= '0;
                end else if (state_q == RUN) begin
                    if (int'(ref_cnt) == REFRESH_PERIOD - 1) ref_cnt <= '0;
                    else                                      ref_cnt <= ref_cnt + 1'b1;
                end
            end

            assign refresh_busy = (state_q == RUN) && (REFRESH_BUSY != 0) &&
                                  (int'(ref_cnt) >= REFRESH_PERIOD - REFRESH_BUSY);
        end else begin : g_no_refresh
            assign refresh_busy = 1'b0;
        end
    endgenerate

    // One-entry write-data buffer plus pending write command; they retire together at commit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wbuf_full <= 1'b0;
            wbuf_data <= '0;
            wbuf_mask <= '0;
            wpend     <= 1'b0;
            widx      <= '0;
        end else begin
            if (beat_acc) begin
                wbuf_full <= 1'b1;
                wbuf_data <= wr_data;
                wbuf_mask <= wr_data_mask;
            end
            if (wr_acc) begin
                wpend <= 1'b1;
                widx  <= line;
            end
            if (commit) begin
                wbuf_full <= 1'b0;
                wpend     <= 1'b0;
            end
        end
    end

    // Read latency pipeline; the RAM is addressed one stage early to absorb its output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rv            <= '0;
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
            for (int i = 0; i < RL - 1; i++) ridx[i] <= '0;
        end else begin
            rv      <= {rv[RL-2:0], rd_acc};
            ridx[0] <= line;
            for (int i = 1; i < RL - 1; i++) ridx[i] <= ridx[i-1];
            rd_data_valid <= rv[RL-1];
            if (rv[RL-1]) rd_data <= ram_q;
        end
    end

    assign rd_data_end = rd_data_valid;

    // Sticky protocol-violation flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            proto_err <= 1'b0;
        end else if (bad_cmd || (wr_data_en != wr_data_end) ||
                     (state_q == CALIB && (cmd_en || wr_data_en))) begin
            proto_err <= 1'b1;
        end
    end

    ddr3_app_mem #(
        .LINES (MEM_LINES),
        .DW    (DDR_DATA_WIDTH),
        .AW    (LW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (commit),
        .wr_addr (widx),
        .wr_be   (~wbuf_mask),
        .wr_data (wbuf_data),
        .rd_en   (rv[RL-2]),
        .rd_addr (ridx[RL-2]),
        .rd_data (ram_q)
    );

endmodule

// File: tb/tb_ddr3_app_emu.sv
// tb/tb_ddr3_app_emu.sv - directed self-checking bench for ddr3_app_emu
module tb_ddr3_app_emu;

    localparam int PERIOD = 32;
    localparam int BUSY   = 4;

    logic         clk;
    logic         reset_n;
    logic         init_calib_complete;
    logic         cmd_ready;
    logic [2:0]   cmd;
    logic         cmd_en;
    logic [28:0]  addr;
    logic         wr_data_rdy;
    logic [127:0] wr_data;
    logic         wr_data_en;
    logic         wr_data_end;
    logic [15:0]  wr_data_mask;
    logic [127:0] rd_data;
    logic         rd_data_valid;
    logic         rd_data_end;
    logic         proto_err;

    int n_tests = 0;
    int n_fail  = 0;
    int phase   = 0;
    bit run_seen = 0;

    localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] DM = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF00;
    localparam logic [127:0] D3 = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
    localparam logic [127:0] D4 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    ddr3_app_emu #(
        .REFRESH_PERIOD (PERIOD),
        .REFRESH_BUSY   (BUSY)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .init_calib_complete (init_calib_complete),
        .cmd_ready           (cmd_ready),
        .cmd                 (cmd),
        .cmd_en              (cmd_en),
        .addr                (addr),
        .wr_data_rdy         (wr_data_rdy),
        .wr_data             (wr_data),
        .wr_data_en          (wr_data_en),
        .wr_data_end         (wr_data_end),
        .wr_data_mask        (wr_data_mask),
        .rd_data             (rd_data),
        .rd_data_valid       (rd_data_valid),
        .rd_data_end         (rd_data_end),
        .proto_err           (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge, sample 1ns later, and track the expected refresh phase
    task automatic tick();
        @(posedge clk);
        #1;
        if (init_calib_complete) begin
            phase    = run_seen ? (phase + 1) % PERIOD : 0;
            run_seen = 1;
        end else begin
            run_seen = 0;
        end
    endtask

    function automatic logic exp_ready();
        return (phase < PERIOD - BUSY);
    endfunction

    task automatic sync0();
        for (int k = 0; k < 2 * PERIOD && phase != 0; k++) tick();
    endtask

    task automatic wait_ready(input string tag);
        for (int k = 0; k < 100 && !cmd_ready; k++) tick();
        check({tag, "_ready"}, cmd_ready, 1);
    endtask

    task automatic do_write(input logic [28:0] a, input logic [127:0] d, input logic [15:0] m, input string tag);
        wait_ready(tag);
        cmd = 3'b000; cmd_en = 1; addr = a;
        wr_data = d; wr_data_mask = m; wr_data_en = 1; wr_data_end = 1;
        tick();
        cmd_en = 0; wr_data_en = 0; wr_data_end = 0;
        wait_ready({tag, "_commit"});
    endtask

    task automatic do_read(input logic [28:0] a, input logic [127:0] exp, input string tag);
        wait_ready(tag);
        cmd = 3'b001; cmd_en = 1; addr = a;
        tick();
        cmd_en = 0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 7) check({tag, "_early"}, rd_data_valid, 0);
            if (k == 8) begin
                check({tag, "_valid"}, rd_data_valid, 1);
                check({tag, "_end"}, rd_data_end, 1);
                check({tag, "_data"}, rd_data, exp);
            end
            if (k == 9) begin
                check({tag, "_drop"}, rd_data_valid, 0);
                check({tag, "_hold"}, rd_data, exp);
            end
        end
    endtask

    initial begin
        logic [28:0]  ra [4];
        logic [127:0] rexp [4];
        int lowcnt;
        int vcount;

        reset_n = 0; cmd = 0; cmd_en = 0; addr = 0;
        wr_data = 0; wr_data_en = 0; wr_data_end = 0; wr_data_mask = 0;
        tick(); tick(); tick();
        check("rst_calib", init_calib_complete, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_wr_rdy", wr_data_rdy, 0);
        check("rst_valid", rd_data_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_proto", proto_err, 0);

        reset_n = 1;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (i == 63) begin
                check("calib_63", init_calib_complete, 0);
                check("calib_cmd_ready", cmd_ready, 0);
                check("calib_wr_rdy", wr_data_rdy, 0);
            end
            if (i == 64) begin
                check("calib_64", init_calib_complete, 1);
                check("run_cmd_ready", cmd_ready, 1);
                check("run_wr_rdy", wr_data_rdy, 1);
            end
        end

        do_write(29'h40, D1, 16'h0000, "wr1");
        do_read(29'h40, D1, "rd1");

        do_write(29'h28, {128{1'b1}}, 16'h0000, "wr_ff");
        do_write(29'h28, 128'h0, 16'hFFFE, "wr_mask");
        do_read(29'h28, DM, "rd_mask");

        sync0();
        wr_data = D3; wr_data_mask = 0; wr_data_en = 1; wr_data_end = 1;
        tick();
        wr_data_en = 0; wr_data_end = 0;
        check("early_beat_rdy", wr_data_rdy, 0);
        tick(); tick();
        cmd = 3'b000; cmd_en = 1; addr = 29'hA0;
        tick();
        cmd_en = 0;
        check("early_wait", cmd_ready, 0);
        tick();
        check("early_commit", cmd_ready, 1);
        check("early_buf_free", wr_data_rdy, 1);
        do_read(29'hA0, D3, "rd_early");

        sync0();
        cmd = 3'b000; cmd_en = 1; addr = 29'hC0;
        tick();
        cmd_en = 0;
        lowcnt = 0;
        if (!cmd_ready) lowcnt++;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (!cmd_ready) lowcnt++;
        end
        wr_data = D4; wr_data_mask = 0; wr_data_en = 1; wr_data_end = 1;
        tick();
        wr_data_en = 0; wr_data_end = 0;
        if (!cmd_ready) lowcnt++;
        check("late_buf_full", wr_data_rdy, 0);
        tick();
        check("late_commit", cmd_ready, 1);
        check("late_low_cycles", lowcnt, 6);
        do_read(29'hC0, D4, "rd_late");

        sync0();
        for (int k = 0; k < 2 * PERIOD; k++) begin
            tick();
            check("refresh_ready", cmd_ready, exp_ready());
        end

        ra[0] = 29'h40; rexp[0] = D1;
        ra[1] = 29'h28; rexp[1] = DM;
        ra[2] = 29'hA0; rexp[2] = D3;
        ra[3] = 29'hC0; rexp[3] = D4;
        sync0();
        cmd = 3'b001;
        for (int j = 0; j < 4; j++) begin
            cmd_en = 1; addr = ra[j];
            tick();
        end
        cmd_en = 0;
        for (int j = 4; j <= 12; j++) begin
            tick();
            if (j >= 8 && j <= 11) begin
                check("b2b_valid", rd_data_valid, 1);
                check("b2b_data", rd_data, rexp[j-8]);
            end else begin
                check("b2b_idle", rd_data_valid, 0);
            end
        end

        sync0();
        check("proto_clean", proto_err, 0);
        cmd = 3'b010; cmd_en = 1; addr = 29'h40;
        tick();
        cmd_en = 0;
        check("proto_set", proto_err, 1);
        check("proto_ignored", cmd_ready, 1);
        tick();
        check("proto_sticky", proto_err, 1);

        sync0();
        cmd = 3'b001;
        for (int j = 0; j < 3; j++) begin
            cmd_en = 1; addr = ra[j];
            tick();
        end
        cmd_en = 0;
        tick(); tick();
        reset_n = 0;
        #1;
        check("mid_rst_valid", rd_data_valid, 0);
        check("mid_rst_calib", init_calib_complete, 0);
        check("mid_rst_proto", proto_err, 0);
        check("mid_rst_data", rd_data, 0);
        vcount = 0;
        tick(); vcount += int'(rd_data_valid);
        tick(); vcount += int'(rd_data_valid);
        reset_n = 1;
        for (int i = 1; i <= 64; i++) begin
            tick();
            vcount += int'(rd_data_valid);
            if (i == 63) check("recal_63", init_calib_complete, 0);
            if (i == 64) check("recal_64", init_calib_complete, 1);
        end
        check("flushed_valids", vcount, 0);
        do_read(29'h28, DM, "rd_retained");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
